// File: rtl/serial_adder_pkg.sv
// serial_adder_pkg: shared FSM state encoding and counter sizing for serial_adder
//   state_t   : IDLE (accepting), RUN (adding one digit per cycle), DONE (holding result)
//   cnt_width : digit-counter width, clog2(n) but never below 1
package serial_adder_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } state_t;

    function automatic int cnt_width(input int n);
        return (n <= 2) ? 1 : $clog2(n);
    endfunction

endpackage

// File: rtl/serial_adder_digit_adder.sv
// digit_adder: combinational W-bit ripple-carry adder built from chained full adders
//   x, y     : W-bit addends
//   ci       : carry into bit 0
//   s        : W-bit sum
//   co       : carry out of bit W-1
//   c_msb_in : carry into bit W-1, used for signed overflow detection
module digit_adder #(
    parameter int W = 1
) (
    input  logic [W-1:0] x,
    input  logic [W-1:0] y,
    input  logic         ci,
    output logic [W-1:0] s,
    output logic         co,
    output logic         c_msb_in
);

    logic [W:0] c;

    assign c[0] = ci;

    // each full adder is two half-adder cells: (x,y) then (partial sum, carry)
    for (genvar i = 0; i < W; i++) begin : g_fa
        logic h1_s, h1_c, h2_c;
        assign h1_s   = x[i] ^ y[i];
        assign h1_c   = x[i] & y[i];
        assign s[i]   = h1_s ^ c[i];
        assign h2_c   = h1_s & c[i];
        assign c[i+1] = h1_c | h2_c;
    end

    assign co       = c[W];
    assign c_msb_in = c[W-1];

endmodule

// File: rtl/serial_adder.sv
// serial_adder: digit-serial adder, DIGIT bits per cycle, LSB digit first,
// with valid/ready handshakes on both sides.
//   clk, rst            : clock and synchronous active-high reset
//   in_valid, in_ready  : operand handshake (in_ready only while idle)
//   a, b, cin           : operands and carry-in, latched on accept
//   sub                 : subtract mode (a - b), present only with SERIAL_ADDER_SUB_EN
//   out_valid, out_ready: result handshake (out_valid only while done)
//   sum, cout, overflow : result, carry out of MSB, signed overflow
module serial_adder
    import serial_adder_pkg::*;
#(
    parameter int WIDTH = 8,
    parameter int DIGIT = 1
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             cin,
`ifdef SERIAL_ADDER_SUB_EN
    input  logic             sub,
`endif
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] sum,
    output logic             cout,
    output logic             overflow
);

    localparam int N  = WIDTH / DIGIT;
    localparam int CW = cnt_width(N);
    localparam logic [CW-1:0] LAST = CW'(N - 1);

    if (WIDTH < 2 || DIGIT < 1 || (WIDTH % DIGIT) != 0) begin : g_bad_params
        $error("serial_adder: WIDTH must be >= 2 and divisible by DIGIT");
    end

    state_t           state;
    logic [CW-1:0]    cnt;
    logic [WIDTH-1:0] a_r, b_r, sum_r;
    logic             c_r, cout_r, ovf_r;
    logic [DIGIT-1:0] d_s;
    logic             d_co, d_cmsb;
    logic [WIDTH-1:0] b_eff;
    logic             c_eff;

    // subtraction is a + ~b + 1, so it reuses the adder with the operand pre-inverted
`ifdef SERIAL_ADDER_SUB_EN
    assign b_eff = sub ? ~b : b;
    assign c_eff = sub | cin;
`else
    assign b_eff = b;
    assign c_eff = cin;
`endif

    digit_adder #(.W(DIGIT)) u_digit (
        .x        (a_r[int'(cnt)*DIGIT +: DIGIT]),
        .y        (b_r[int'(cnt)*DIGIT +: DIGIT]),
        .ci       (c_r),
        .s        (d_s),
        .co       (d_co),
        .c_msb_in (d_cmsb)
    );

    always_ff @(posedge clk) begin
        if (rst) begin
            state  <= IDLE;
            cnt    <= '0;
            c_r    <= 1'b0;
            a_r    <= '0;
            b_r    <= '0;
            sum_r  <= '0;
            cout_r <= 1'b0;
            ovf_r  <= 1'b0;
        end else begin
            case (state)
                IDLE: if (in_valid) begin
                    a_r   <= a;
                    b_r   <= b_eff;
                    c_r   <= c_eff;
                    cnt   <= '0;
                    state <= RUN;
                end
                RUN: begin
                    sum_r[int'(cnt)*DIGIT +: DIGIT] <= d_s;
                    c_r <= d_co;
                    cnt <= cnt + 1'b1;
                    if (cnt == LAST) begin
                        cout_r <= d_co;
                        ovf_r  <= d_cmsb ^ d_co;
                        state  <= DONE;
                    end
                end
                DONE: if (out_ready) state <= IDLE;
                default: state <= IDLE;
            endcase
        end
    end

    assign in_ready  = (state == IDLE);
    assign out_valid = (state == DONE);
    assign sum       = sum_r;
    assign cout      = cout_r;
    assign overflow  = ovf_r;

endmodule

// File: tb/tb_serial_adder.sv
// tb_serial_adder: self-checking bench for serial_adder, DIGIT=1 and DIGIT=4 instances
module tb_serial_adder;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic [7:0] a = '0, b = '0;
    logic       cin = 1'b0;
`ifdef SERIAL_ADDER_SUB_EN
    logic       sub = 1'b0;
`endif
    logic       iv[2], ir[2], ov[2], ordy[2], co[2], of[2];
    logic [7:0] s[2];
    int         total = 0;
    int         bad = 0;

    always #5 clk = ~clk;

    serial_adder #(.WIDTH(8), .DIGIT(1)) u1 (
        .clk(clk), .rst(rst), .in_valid(iv[0]), .in_ready(ir[0]),
        .a(a), .b(b), .cin(cin),
`ifdef SERIAL_ADDER_SUB_EN
        .sub(sub),
`endif
        .out_valid(ov[0]), .out_ready(ordy[0]),
        .sum(s[0]), .cout(co[0]), .overflow(of[0])
    );

    serial_adder #(.WIDTH(8), .DIGIT(4)) u4 (
        .clk(clk), .rst(rst), .in_valid(iv[1]), .in_ready(ir[1]),
        .a(a), .b(b), .cin(cin),
`ifdef SERIAL_ADDER_SUB_EN
        .sub(sub),
`endif
        .out_valid(ov[1]), .out_ready(ordy[1]),
        .sum(s[1]), .cout(co[1]), .overflow(of[1])
    );

    // reference: whole-word arithmetic, overflow from operand/result signs
    function automatic logic [9:0] model(input logic [7:0] x, input logic [7:0] y,
                                         input logic ci, input logic sb);
        logic [7:0] yy;
        logic [8:0] f;
        logic       v;
        yy = sb ? ~y : y;
        f  = {1'b0, x} + {1'b0, yy} + 9'(sb ? 1'b1 : ci);
        v  = (x[7] == yy[7]) && (f[7] != x[7]);
        return {v, f[8], f[7:0]};
    endfunction

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic set_ops(input logic [7:0] x, input logic [7:0] y, input logic ci, input logic sb);
        a = x;
        b = y;
        cin = ci;
`ifdef SERIAL_ADDER_SUB_EN
        sub = sb;
`endif
    endtask

    task automatic run_op(input int k, input logic [7:0] x, input logic [7:0] y,
                          input logic ci, input logic sb, input logic [9:0] exp, input string nm);
        int n;
        int lat;
        n = (k == 0) ? 8 : 2;
        set_ops(x, y, ci, sb);
        iv[k] = 1'b1;
        lat = 0;
        while (!ir[k] && lat < 20) begin
            tick();
            lat++;
        end
        total++;
        if (ir[k] !== 1'b1) begin
            bad++;
            $display("FAIL %s accept: in_ready=%b required 1", nm, ir[k]);
            iv[k] = 1'b0;
            return;
        end
        tick();
        iv[k] = 1'b0;
        set_ops(8'($urandom), 8'($urandom), 1'($urandom), 1'($urandom));
        lat = 0;
        while (!ov[k] && lat < 40) begin
            tick();
            lat++;
        end
        total++;
        if (lat !== n) begin
            bad++;
            $display("FAIL %s latency: got %0d required %0d", nm, lat, n);
        end
        total++;
        if (s[k] !== exp[7:0]) begin
            bad++;
            $display("FAIL %s sum: got %h required %h", nm, s[k], exp[7:0]);
        end
        total++;
        if (co[k] !== exp[8]) begin
            bad++;
            $display("FAIL %s cout: got %b required %b", nm, co[k], exp[8]);
        end
        total++;
        if (of[k] !== exp[9]) begin
            bad++;
            $display("FAIL %s overflow: got %b required %b", nm, of[k], exp[9]);
        end
        ordy[k] = 1'b1;
        tick();
        ordy[k] = 1'b0;
        total++;
        if (ir[k] !== 1'b1 || ov[k] !== 1'b0) begin
            bad++;
            $display("FAIL %s release: in_ready=%b out_valid=%b required 1/0", nm, ir[k], ov[k]);
        end
    endtask

    task automatic test_reset();
        rst = 1'b1;
        tick();
        tick();
        for (int k = 0; k < 2; k++) begin
            total++;
            if (ir[k] !== 1'b1 || ov[k] !== 1'b0) begin
                bad++;
                $display("FAIL reset%0d handshake: in_ready=%b out_valid=%b required 1/0", k, ir[k], ov[k]);
            end
            total++;
            if ({s[k], co[k], of[k]} !== 10'b0) begin
                bad++;
                $display("FAIL reset%0d outputs: sum=%h cout=%b ovf=%b required 0", k, s[k], co[k], of[k]);
            end
        end
        rst = 1'b0;
        tick();
    endtask

    task automatic test_directed();
        run_op(0, 8'h01, 8'h01, 1'b0, 1'b0, {1'b0, 1'b0, 8'h02}, "d1_1p1");
        run_op(0, 8'hFF, 8'h01, 1'b0, 1'b0, {1'b0, 1'b1, 8'h00}, "d1_ffp1");
        run_op(0, 8'h7F, 8'h01, 1'b0, 1'b0, {1'b1, 1'b0, 8'h80}, "d1_7fp1");
        run_op(1, 8'hA5, 8'h5A, 1'b1, 1'b0, {1'b0, 1'b1, 8'h00}, "d4_a5p5a");
    endtask

    task automatic test_sub();
`ifdef SERIAL_ADDER_SUB_EN
        run_op(0, 8'h05, 8'h07, 1'b0, 1'b1, {1'b0, 1'b0, 8'hFE}, "sub1_5m7");
        run_op(0, 8'h80, 8'h01, 1'b0, 1'b1, {1'b1, 1'b1, 8'h7F}, "sub1_80m1");
        run_op(1, 8'h80, 8'h01, 1'b1, 1'b1, {1'b1, 1'b1, 8'h7F}, "sub4_80m1");
`endif
    endtask

    task automatic test_backpressure();
        logic [9:0] exp;
        int lat;
        exp = model(8'h3C, 8'h55, 1'b1, 1'b0);
        set_ops(8'h3C, 8'h55, 1'b1, 1'b0);
        iv[0] = 1'b1;
        tick();
        iv[0] = 1'b0;
        lat = 0;
        while (!ov[0] && lat < 40) begin
            tick();
            lat++;
        end
        set_ops(8'hC3, 8'hAA, 1'b0, 1'b0);
        iv[0] = 1'b1;
        for (int i = 0; i < 5; i++) begin
            tick();
            total++;
            if (ov[0] !== 1'b1 || ir[0] !== 1'b0) begin
                bad++;
                $display("FAIL bp hold%0d: out_valid=%b in_ready=%b required 1/0", i, ov[0], ir[0]);
            end
            total++;
            if ({of[0], co[0], s[0]} !== exp) begin
                bad++;
                $display("FAIL bp stable%0d: got %h required %h", i, {of[0], co[0], s[0]}, exp);
            end
        end
        iv[0] = 1'b0;
        ordy[0] = 1'b1;
        tick();
        ordy[0] = 1'b0;
        total++;
        if (ir[0] !== 1'b1 || ov[0] !== 1'b0) begin
            bad++;
            $display("FAIL bp release: in_ready=%b out_valid=%b required 1/0", ir[0], ov[0]);
        end
    endtask

    task automatic test_reset_mid_run();
        int seen;
        set_ops(8'h12, 8'h34, 1'b0, 1'b0);
        iv[0] = 1'b1;
        tick();
        iv[0] = 1'b0;
        tick();
        tick();
        rst = 1'b1;
        tick();
        rst = 1'b0;
        total++;
        if (ir[0] !== 1'b1 || ov[0] !== 1'b0 || s[0] !== 8'h00) begin
            bad++;
            $display("FAIL midrst state: in_ready=%b out_valid=%b sum=%h required 1/0/00", ir[0], ov[0], s[0]);
        end
        seen = 0;
        for (int i = 0; i < 12; i++) begin
            tick();
            if (ov[0] === 1'b1) seen++;
        end
        total++;
        if (seen != 0) begin
            bad++;
            $display("FAIL midrst pulse: out_valid high %0d cycles required 0", seen);
        end
        run_op(0, 8'h9C, 8'h77, 1'b1, 1'b0, model(8'h9C, 8'h77, 1'b1, 1'b0), "midrst_next");
    endtask

    task automatic test_random();
        logic [7:0] x, y;
        logic ci, sb;
        for (int i = 0; i < 24; i++) begin
            x  = 8'($urandom);
            y  = 8'($urandom);
            ci = 1'($urandom);
`ifdef SERIAL_ADDER_SUB_EN
            sb = 1'($urandom);
`else
            sb = 1'b0;
`endif
            run_op(i % 2, x, y, ci, sb, model(x, y, ci, sb), $sformatf("rand%0d", i));
        end
    endtask

    task automatic test_back_to_back();
        for (int i = 0; i < 4; i++)
            run_op(1, 8'(8'h40 * i), 8'hC0, 1'b0, 1'b0, model(8'(8'h40 * i), 8'hC0, 1'b0, 1'b0),
                   $sformatf("b2b%0d", i));
    endtask

    initial begin
        iv[0] = 1'b0;
        iv[1] = 1'b0;
        ordy[0] = 1'b0;
        ordy[1] = 1'b0;
        test_reset();
        test_directed();
        test_sub();
        test_backpressure();
        test_reset_mid_run();
        test_random();
        test_back_to_back();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
